// File: rtl/mux_pkg.sv
// Shared constants and beat type for the pipelined N-input mux.
package mux_pkg;

    localparam int WIDTH_DEF      = 16;
    localparam int NUM_INPUTS_DEF = 3;
    localparam int SEL_W_DEF      = 3;
    localparam int ERR_CNT_W      = 8;

    // Beat at default width; parameterized instances mirror this layout locally.
    typedef struct packed {
        logic [WIDTH_DEF-1:0] data;
        logic                 sel_err;
    } beat_t;

endpackage

// File: rtl/mux_sel_check.sv
// Combinational select-and-check: forwards input in_sel, or zero plus an error flag when out of range.
module mux_sel_check #(
    parameter int WIDTH      = 16,
    parameter int NUM_INPUTS = 3,
    parameter int SEL_W      = 3
) (
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]            in_sel,
    output logic [WIDTH-1:0]            data,
    output logic                        sel_err
);

    always_comb begin
        data    = '0;
        sel_err = 1'b1;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (int'(in_sel) == k) begin
                data    = in_data[k*WIDTH +: WIDTH];
                sel_err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_n_inputs_pipe.sv
// One-cycle registered N-input mux with a two-entry (output + skid) buffer.
// Optional bad-select counter enabled by defining SEL_ERR_COUNT_EN.
module mux_n_inputs_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int NUM_INPUTS = NUM_INPUTS_DEF,
    parameter int SEL_W      = SEL_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]            in_sel,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_sel_err,
    output logic                        out_valid,
    input  logic                        out_ready
`ifdef SEL_ERR_COUNT_EN
    ,
    input  logic                        err_clr,
    output logic [ERR_CNT_W-1:0]        err_count
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             sel_err;
    } stage_t;

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    stage_t           new_beat;
    stage_t           out_q;
    stage_t           skid_q;
    logic             out_v;
    logic             skid_v;
    logic             ready_q;
    logic             accept;
    logic             drain;

    mux_sel_check #(
        .WIDTH      (WIDTH),
        .NUM_INPUTS (NUM_INPUTS),
        .SEL_W      (SEL_W)
    ) u_sel_check (
        .in_data (in_data),
        .in_sel  (in_sel),
        .data    (sel_data),
        .sel_err (sel_err)
    );

    assign new_beat = '{data: sel_data, sel_err: sel_err};
    assign accept   = in_valid & ready_q;
    assign drain    = out_v & out_ready;

    // ready_q tracks "skid empty" as its own flop so in_ready never sees out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            skid_q  <= '0;
            out_v   <= 1'b0;
            skid_v  <= 1'b0;
            ready_q <= 1'b1;
        end else if (!out_v || drain) begin
            if (skid_v) begin
                out_q   <= skid_q;
                out_v   <= 1'b1;
                skid_v  <= 1'b0;
                ready_q <= 1'b1;
            end else if (accept) begin
                out_q <= new_beat;
                out_v <= 1'b1;
            end else begin
                out_v <= 1'b0;
            end
        end else if (accept) begin
            skid_q  <= new_beat;
            skid_v  <= 1'b1;
            ready_q <= 1'b0;
        end
    end

    assign in_ready    = ready_q;
    assign out_valid   = out_v;
    assign out_data    = out_q.data;
    assign out_sel_err = out_q.sel_err;

`ifdef SEL_ERR_COUNT_EN
    // Clear has priority over a same-cycle increment; count saturates at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (accept && sel_err && (err_count != '1)) begin
            err_count <= err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule

// File: doc/mux_n_inputs_pipe.md
MUX_N_INPUTS_PIPE -- requirements
Module: mux_n_inputs_pipe

Interface
REQ-001 The parameters SHALL be as follows, one per line:
- WIDTH, 16, data bits per input and output.
- NUM_INPUTS, 3, number of data inputs; legal range 2..16.
- SEL_W, 3, select width; SEL_W SHALL be at least $clog2(NUM_INPUTS).
REQ-002 The ports SHALL be as follows, one per line:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  NUM_INPUTS*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  index of the input to forward.
- in_valid  input  1  request beat present.
- in_ready  output  1  block can accept a beat.
- out_data  output  WIDTH  selected data.
- out_sel_err  output  1  current output beat had an out-of-range select.
- out_valid  output  1  output beat present.
- out_ready  input  1  consumer accepts the beat.
- err_clr  input  1  clears err_count (SEL_ERR_COUNT_EN only).
- err_count  output  8  saturating count of bad selects (SEL_ERR_COUNT_EN only).

Function
REQ-003 A beat SHALL be accepted on a rising edge when in_valid and in_ready are both 1; the data, the select-error flag and the select SHALL be captured together.
REQ-004 If in_sel < NUM_INPUTS, the captured data SHALL be input in_sel and the flag SHALL be 0; otherwise the data SHALL be 0 and the flag SHALL be 1.
REQ-005 Latency SHALL be exactly one cycle: an accepted beat SHALL appear on out_data/out_valid the next cycle when the output stage is empty or draining.
REQ-006 Storage SHALL be two entries: the main output register plus one skid register.
REQ-007 in_ready SHALL be a registered signal equal to "skid register empty", with no combinational path from out_ready.
REQ-008 While out_valid=1 and out_ready=0, out_data and out_sel_err SHALL hold stable.
REQ-009 When the output register drains and the skid register is full, the skid content SHALL move to the output in the same edge.
REQ-010 Simultaneous accept and drain with the skid register empty SHALL replace the output register directly and keep out_valid=1, with no bubble.
REQ-011 An accept while the output register is stalled SHALL go to the skid register; in_ready SHALL then drop the next cycle.
REQ-012 Beat order SHALL be preserved; no beat SHALL be dropped or duplicated.
REQ-013 Full throughput of one beat per cycle SHALL be sustained while out_ready=1.

Reset
REQ-014 While rst=1, out_valid=0, out_data=0, out_sel_err=0, the skid register SHALL be empty and in_ready=1 on the first edge after release; err_count=0.
REQ-015 Reset asserted mid-transfer SHALL discard both entries immediately, asynchronously; no partial beat SHALL appear after release.

Configuration
REQ-016 Macro SEL_ERR_COUNT_EN defined: err_count SHALL increment by 1 on each accepted beat with an out-of-range select.
- It SHALL saturate at 255.
- err_clr=1 SHALL zero it on the next edge; clear SHALL win over a simultaneous increment.
REQ-017 Macro SEL_ERR_COUNT_EN undefined: the err_clr and err_count ports and the counter logic SHALL be absent. All other behaviour SHALL be identical.

Structure
REQ-018 A shared package mux_pkg SHALL hold:
- the default WIDTH, NUM_INPUTS and SEL_W constants;
- the ERR_CNT_W=8 constant;
- a struct typedef for a stored beat {data, sel_err}.
REQ-019 The select-and-check logic SHALL be one combinational sub-module, mux_sel_check (in_data, in_sel -> data, sel_err). The top SHALL instantiate it once and hold the two-entry buffer.

Verification
REQ-020 The bench SHALL cover these directed scenarios (defaults, in_data = {0xCCCC, 0xBBBB, 0xAAAA}):
- Select sequence 0,1,2 with out_ready=1 -> out 0xAAAA, 0xBBBB, 0xCCCC on consecutive cycles, each one cycle after accept, out_sel_err=0.
- in_sel=3 and in_sel=7 -> out_data=0x0000, out_sel_err=1; with the macro, err_count=2.
- out_ready=0 for 4 cycles while sending 3 beats -> 2 beats stored, in_ready=0 from the cycle after the second accept, third beat not accepted. out_ready=1 then yields beats in order with no loss.
- rst pulsed while both entries are full -> out_valid=0 immediately; after release in_ready=1 and no stale beat appears.
- Macro defined, 300 bad selects -> err_count=255. err_clr together with a bad select -> err_count=0.
- NUM_INPUTS=16, WIDTH=32, SEL_W=4: every index 0..15 returns its input; random backpressure shows no order or data errors.
